// File: rtl/pwm_pkg.sv
// Shared register map and CTRL bit positions for the multi-channel PWM timer.
package pwm_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_PRESC  = 1;
  localparam int ADDR_PERIOD = 2;
  localparam int ADDR_STATUS = 3;
  localparam int ADDR_DUTY0  = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CENTER = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_counter.sv
// Shared prescaler plus edge (saw) or center (triangle) period counter.
// wrap_o pulses on the tick where the counter returns to 0.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             center_i,
  input  logic [PRE_W-1:0] presc_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [PRE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             wrap_d;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    if (!en_i) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_d       = DIR_UP;
    end else if (presc_cnt_q >= presc_i) begin
      // >= so that lowering PRESC mid-count ticks at once instead of rolling over
      presc_cnt_d = '0;
      if (!center_i) begin
        dir_d = DIR_UP;
        if (cnt_q >= period_i) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (period_i == '0) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (dir_q == DIR_DOWN || cnt_q >= period_i) begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d  = '0;
          dir_d  = DIR_UP;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_d;

endmodule

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: bus register window, shadowed period/duty/mode,
// one shared counter and a registered compare output per channel.
module pwm_timer_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  duty_q [NUM_CH];
  logic [CNT_W-1:0]  duty_d [NUM_CH];
  logic              wrap_q, wrap_d;

  logic              center_act_q;
  logic [CNT_W-1:0]  period_act_q;
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];

  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [31:0]       rdata_q, rd_val;
  logic [CNT_W-1:0]  cnt;
  logic              wrap_ev;
  logic              wr_status;
  logic              unused_wdata;

  assign wr_status    = we && (addr == ADDR_W'(ADDR_STATUS));
  assign unused_wdata = ^wdata;

  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    period_d = period_q;
    if (we && addr == ADDR_W'(ADDR_CTRL))   ctrl_d   = wdata[CTRL_W-1:0];
    if (we && addr == ADDR_W'(ADDR_PRESC))  presc_d  = wdata[PRE_W-1:0];
    if (we && addr == ADDR_W'(ADDR_PERIOD)) period_d = wdata[CNT_W-1:0];
    // a wrap in the same cycle as a W1C keeps the flag set
    wrap_d = wrap_ev | (wrap_q & ~(wr_status & wdata[0]));
    for (int i = 0; i < NUM_CH; i++) begin
      duty_d[i] = duty_q[i];
      if (we && addr == ADDR_W'(ADDR_DUTY0 + i)) duty_d[i] = wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    if (addr == ADDR_W'(ADDR_CTRL))   rd_val[CTRL_W-1:0] = ctrl_q;
    if (addr == ADDR_W'(ADDR_PRESC))  rd_val[PRE_W-1:0]  = presc_q;
    if (addr == ADDR_W'(ADDR_PERIOD)) rd_val[CNT_W-1:0]  = period_q;
    if (addr == ADDR_W'(ADDR_STATUS)) rd_val[0]          = wrap_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(ADDR_DUTY0 + i)) rd_val[CNT_W-1:0] = duty_q[i];
    end
  end

  pwm_counter #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (ctrl_q[CTRL_EN]),
    .center_i(center_act_q),
    .presc_i (presc_q),
    .period_i(period_act_q),
    .cnt_o   (cnt),
    .wrap_o  (wrap_ev)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pwm_d[i] = ctrl_q[CTRL_EN] & (cnt < duty_act_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      presc_q      <= '0;
      period_q     <= '0;
      duty_q       <= '{default: '0};
      wrap_q       <= 1'b0;
      center_act_q <= 1'b0;
      period_act_q <= '0;
      duty_act_q   <= '{default: '0};
      pwm_q        <= '0;
      rdata_q      <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      wrap_q   <= wrap_d;
      // staging flows straight through while stopped, else only at the period boundary
      if (!ctrl_q[CTRL_EN] || wrap_ev) begin
        center_act_q <= ctrl_d[CTRL_CENTER];
        period_act_q <= period_d;
        duty_act_q   <= duty_d;
      end
      pwm_q <= pwm_d;
      if (re) rdata_q <= rd_val;
    end
  end

  assign rdata   = rdata_q;
  assign pwm_out = pwm_q;
  assign irq     = wrap_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi: register table plus waveform sequences
// with hand-computed expected patterns fed through an expected queue.
module tb_pwm_timer_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 8;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              we;
  logic              re;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] pwm_out;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_CH-1:0] exp_q[$];

  typedef struct packed {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [24];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pwm_timer_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .PRE_W (PRE_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .pwm_out(pwm_out),
    .irq    (irq)
  );

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    addr  = ADDR_W'(a);
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    addr = ADDR_W'(a);
    re   = 1'b1;
    @(negedge clk);
    re   = 1'b0;
    d    = rdata;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard: drains exp_q one sample per cycle ----------------
  task automatic drain_expect(input string name);
    int k;
    logic [NUM_CH-1:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, k), 32'(pwm_out), 32'(e));
      k++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd;
    logic        b;

    // reset held for 2 cycles with a write strobe active
    rst = 1'b1; we = 1'b1; re = 1'b0; addr = '0; wdata = 32'h7;
    repeat (2) @(negedge clk);
    rst = 1'b0; we = 1'b0;
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rdata", rdata, 32'h0);

    // register table: reads of reset values, then write/readback pairs
    vecs[0]  = '{1'b0, 5'd0,  32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd1,  32'h0, 32'h0};
    vecs[2]  = '{1'b0, 5'd2,  32'h0, 32'h0};
    vecs[3]  = '{1'b0, 5'd3,  32'h0, 32'h0};
    vecs[4]  = '{1'b0, 5'd4,  32'h0, 32'h0};
    vecs[5]  = '{1'b0, 5'd5,  32'h0, 32'h0};
    vecs[6]  = '{1'b0, 5'd6,  32'h0, 32'h0};
    vecs[7]  = '{1'b0, 5'd7,  32'h0, 32'h0};
    vecs[8]  = '{1'b0, 5'd8,  32'h0, 32'h0};
    vecs[9]  = '{1'b0, 5'd31, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 5'd0,  32'hFFFF_FFF6, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0, 32'h6};
    vecs[12] = '{1'b1, 5'd1,  32'h0000_01FF, 32'h0};
    vecs[13] = '{1'b0, 5'd1,  32'h0, 32'hFF};
    vecs[14] = '{1'b1, 5'd2,  32'h0001_2345, 32'h0};
    vecs[15] = '{1'b0, 5'd2,  32'h0, 32'h2345};
    vecs[16] = '{1'b1, 5'd3,  32'h1, 32'h0};
    vecs[17] = '{1'b0, 5'd3,  32'h0, 32'h0};
    vecs[18] = '{1'b1, 5'd7,  32'hDEAD_ABCD, 32'h0};
    vecs[19] = '{1'b0, 5'd7,  32'h0, 32'hABCD};
    vecs[20] = '{1'b1, 5'd8,  32'hFFFF_FFFF, 32'h0};
    vecs[21] = '{1'b0, 5'd8,  32'h0, 32'h0};
    vecs[22] = '{1'b1, 5'd4,  32'h5, 32'h0};
    vecs[23] = '{1'b0, 5'd4,  32'h0, 32'h5};
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) begin
        bus_wr(int'(vecs[i].a), vecs[i].d);
      end else begin
        bus_rd(int'(vecs[i].a), rd);
        check($sformatf("regvec%0d_addr%0d", i, vecs[i].a), rd, vecs[i].exp);
      end
    end
    // rdata holds while re is low
    @(negedge clk);
    check("rdata_hold", rdata, 32'h5);

    // edge mode: PERIOD=9, duties 3/0/10/0 -> ch0 3 high of 10, ch1 low, ch2 high
    do_reset();
    bus_wr(1, 0);
    bus_wr(2, 9);
    bus_wr(4, 3);
    bus_wr(5, 0);
    bus_wr(6, 10);
    bus_wr(7, 0);
    bus_wr(0, 32'h1);
    for (int k = 0; k < 20; k++) begin
      b = ((k % 10) < 3);
      exp_q.push_back({1'b0, 1'b1, 1'b0, b});
    end
    drain_expect("edge");

    // center mode: PRESC=1, PERIOD=4, DUTY0=2 -> 16-cycle period, 6 high around cnt=0
    bus_wr(0, 32'h0);
    bus_wr(1, 1);
    bus_wr(2, 4);
    bus_wr(4, 2);
    bus_wr(0, 32'h3);
    for (int j = 0; j < 32; j++) begin
      b = ((j % 16) < 4) || ((j % 16) >= 14);
      exp_q.push_back({1'b0, 1'b1, 1'b0, b});
    end
    drain_expect("center");

    // shadow: DUTY0 3 -> 7 written mid-period, active at next cnt=0
    bus_wr(0, 32'h0);
    bus_wr(1, 0);
    bus_wr(2, 9);
    bus_wr(4, 3);
    bus_wr(0, 32'h1);
    repeat (4) @(negedge clk);
    bus_wr(4, 7);
    bus_rd(4, rd);
    check("shadow_readback", rd, 32'h7);
    for (int k = 6; k < 26; k++) begin
      b = (k < 10) ? ((k % 10) < 3) : ((k % 10) < 7);
      exp_q.push_back({1'b0, 1'b1, 1'b0, b});
    end
    drain_expect("shadow");

    // reset while running returns everything to idle
    do_reset();
    check("midrun_reset_pwm", 32'(pwm_out), 32'h0);
    check("midrun_reset_irq", 32'(irq), 32'h0);

    // interrupt: PERIOD=4, irq 5 cycles after enable, W1C, W1C on wrap cycle
    bus_wr(2, 4);
    bus_wr(4, 5);
    bus_wr(0, 32'h5);
    check("irq_c1", 32'(irq), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("irq_c%0d", i), 32'(irq), 32'h0);
    end
    @(negedge clk);
    check("irq_c6_rise", 32'(irq), 32'h1);
    bus_wr(3, 32'h1);
    check("irq_w1c", 32'(irq), 32'h0);
    bus_rd(3, rd);
    check("status_cleared", rd, 32'h0);
    repeat (2) @(negedge clk);
    bus_wr(3, 32'h1);
    check("irq_w1c_on_wrap", 32'(irq), 32'h1);
    bus_rd(3, rd);
    check("status_set_wins", rd, 32'h1);
    check("duty_gt_period_high", 32'(pwm_out), 32'h1);

    // disable mid-period, then restart with staged PERIOD=2
    bus_wr(2, 2);
    bus_wr(0, 32'h0);
    @(negedge clk);
    check("disable_pwm_low", 32'(pwm_out), 32'h0);
    bus_wr(4, 2);
    bus_wr(0, 32'h1);
    for (int j = 0; j < 9; j++) begin
      b = ((j % 3) < 2);
      exp_q.push_back({1'b0, 1'b0, 1'b0, b});
    end
    drain_expect("restart");

    // PERIOD_act=0: edge wraps every tick, center holds with no wrap
    do_reset();
    bus_wr(4, 1);
    bus_wr(0, 32'h5);
    @(negedge clk);
    check("p0_edge_irq", 32'(irq), 32'h1);
    check("p0_edge_pwm", 32'(pwm_out), 32'h1);
    bus_wr(3, 32'h1);
    check("p0_edge_rewrap", 32'(irq), 32'h1);
    bus_wr(0, 32'h7);
    bus_wr(3, 32'h1);
    check("p0_center_clear", 32'(irq), 32'h0);
    repeat (4) @(negedge clk);
    check("p0_center_no_wrap", 32'(irq), 32'h0);
    check("p0_center_pwm", 32'(pwm_out), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
